pc_sequencer: RTL and testbench

- Program-counter stage directly upstream of the instruction fetch stage.
- Owns the architectural PC register and drives current_pc into the 256-word instruction ROM lookup.
- Selects the next PC from sequential increment, taken branch, jump, call or return.
- Holds a small hardware return-address stack, plus halt and fault state, so the 8-bit core can run subroutines without data-memory traffic.

---
 rtl/pc_sequencer_if.sv | 34 +++
 rtl/pc_sequencer.sv | 121 ++++++++++++
 tb/tb_pc_sequencer.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// Control and status bundle between the branch/decode logic (master) and the
// PC sequencer (slave).
interface pc_sequencer_if #(
    parameter int PC_WIDTH    = 8,
    parameter int STACK_DEPTH = 4
);
    localparam int LEVEL_WIDTH = $clog2(STACK_DEPTH) + 1;

    logic                   stall;
    logic                   branch_taken;
    logic [PC_WIDTH-1:0]    branch_target;
    logic                   jump;
    logic [PC_WIDTH-1:0]    jump_target;
    logic                   call;
    logic                   ret;
    logic                   halt;
    logic                   resume;
    logic [PC_WIDTH-1:0]    current_pc;
    logic                   halted;
    logic                   fault;
    logic [LEVEL_WIDTH-1:0] stack_level;

    modport master (
        output stall, branch_taken, branch_target, jump, jump_target,
               call, ret, halt, resume,
        input  current_pc, halted, fault, stack_level
    );

    modport slave (
        input  stall, branch_taken, branch_target, jump, jump_target,
               call, ret, halt, resume,
        output current_pc, halted, fault, stack_level
    );
endinterface

// File: rtl/pc_sequencer.sv
// Architectural PC register with next-PC selection, a hardware return-address
// stack and RUN/HALT/FAULT control for the 8-bit core's fetch stage.
module pc_sequencer #(
    parameter int                  PC_WIDTH     = 8,
    parameter int                  STACK_DEPTH  = 4,
    parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
    input  logic           clk,
    input  logic           rst_n,
    pc_sequencer_if.slave  bus
);
    localparam int PTR_WIDTH   = $clog2(STACK_DEPTH);
    localparam int LEVEL_WIDTH = PTR_WIDTH + 1;
    localparam logic [LEVEL_WIDTH-1:0] FULL_LEVEL = LEVEL_WIDTH'(STACK_DEPTH);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_HALT,
        ST_FAULT
    } state_t;

    state_t                 state_q;
    logic [PC_WIDTH-1:0]    pc_q;
    logic [LEVEL_WIDTH-1:0] level_q;
    logic                   halted_q;
    logic                   fault_q;

    logic [PC_WIDTH-1:0]    stack_mem [STACK_DEPTH];
    logic [PC_WIDTH-1:0]    pc_plus_one;
    logic [PC_WIDTH-1:0]    stack_top;
    logic [LEVEL_WIDTH-1:0] level_dec;
    logic [LEVEL_WIDTH-1:0] level_inc;
    logic [PTR_WIDTH-1:0]   push_ptr;
    logic [PTR_WIDTH-1:0]   pop_ptr;
    logic                   stack_empty;
    logic                   stack_full;
    logic                   do_push;

    assign pc_plus_one = pc_q + PC_WIDTH'(1);
    assign level_dec   = level_q - LEVEL_WIDTH'(1);
    assign level_inc   = level_q + LEVEL_WIDTH'(1);
    assign push_ptr    = level_q[PTR_WIDTH-1:0];
    assign pop_ptr     = level_dec[PTR_WIDTH-1:0];
    assign stack_top   = stack_mem[pop_ptr];
    assign stack_empty = (level_q == '0);
    assign stack_full  = (level_q == FULL_LEVEL);

    // A push only happens when call is the winning control in RUN; the
    // decode mirrors the priority chain in the state machine below.
    assign do_push = (state_q == ST_RUN) && !bus.stall && !bus.halt &&
                     !bus.ret && bus.call && !stack_full;

    // Stack contents are don't-care after reset, so the storage has no reset.
    always_ff @(posedge clk) begin
        if (do_push) begin
            stack_mem[push_ptr] <= pc_plus_one;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_RUN;
            pc_q     <= RESET_VECTOR;
            level_q  <= '0;
            halted_q <= 1'b0;
            fault_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_RUN: begin
                    if (!bus.stall) begin
                        if (bus.halt) begin
                            state_q  <= ST_HALT;
                            halted_q <= 1'b1;
                        end else if (bus.ret) begin
                            if (stack_empty) begin
                                state_q <= ST_FAULT;
                                fault_q <= 1'b1;
                            end else begin
                                pc_q    <= stack_top;
                                level_q <= level_dec;
                            end
                        end else if (bus.call) begin
                            if (stack_full) begin
                                state_q <= ST_FAULT;
                                fault_q <= 1'b1;
                            end else begin
                                pc_q    <= bus.jump_target;
                                level_q <= level_inc;
                            end
                        end else if (bus.jump) begin
                            pc_q <= bus.jump_target;
                        end else if (bus.branch_taken) begin
                            pc_q <= bus.branch_target;
                        end else begin
                            pc_q <= pc_plus_one;
                        end
                    end
                end
                ST_HALT: begin
                    // PC is not advanced on resume so the halted instruction is re-fetched.
                    if (!bus.stall && bus.resume) begin
                        state_q  <= ST_RUN;
                        halted_q <= 1'b0;
                    end
                end
                ST_FAULT: begin
                end
                default: begin
                    state_q  <= ST_FAULT;
                    halted_q <= 1'b0;
                    fault_q  <= 1'b1;
                end
            endcase
        end
    end

    assign bus.current_pc  = pc_q;
    assign bus.halted      = halted_q;
    assign bus.fault       = fault_q;
    assign bus.stack_level = level_q;
endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer: counting, branch/jump
// priority, stall, call/return, stack overflow/underflow faults and halt/resume.
module tb_pc_sequencer;
    localparam int C_STALL  = 1;
    localparam int C_BRANCH = 2;
    localparam int C_JUMP   = 4;
    localparam int C_CALL   = 8;
    localparam int C_RET    = 16;
    localparam int C_HALT   = 32;
    localparam int C_RESUME = 64;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;

    pc_sequencer_if #(.PC_WIDTH(8), .STACK_DEPTH(4)) bus ();

    pc_sequencer #(
        .PC_WIDTH    (8),
        .STACK_DEPTH (4),
        .RESET_VECTOR(8'h00)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    task automatic check_output(input string tag, input logic [7:0] exp_pc,
                                input logic exp_halted, input logic exp_fault,
                                input logic [2:0] exp_level);
        checks++;
        assert (bus.current_pc === exp_pc) else begin
            errors++;
            $error("[TB] FAIL %s pc: observed %h expected %h", tag, bus.current_pc, exp_pc);
        end
        checks++;
        assert (bus.halted === exp_halted) else begin
            errors++;
            $error("[TB] FAIL %s halted: observed %b expected %b", tag, bus.halted, exp_halted);
        end
        checks++;
        assert (bus.fault === exp_fault) else begin
            errors++;
            $error("[TB] FAIL %s fault: observed %b expected %b", tag, bus.fault, exp_fault);
        end
        checks++;
        assert (bus.stack_level === exp_level) else begin
            errors++;
            $error("[TB] FAIL %s stack_level: observed %0d expected %0d", tag, bus.stack_level, exp_level);
        end
    endtask

    // Drives one cycle of controls, lets one rising edge pass, then samples 1ns later.
    task automatic apply_stimulus(input int ctl, input logic [7:0] br_tgt, input logic [7:0] jmp_tgt);
        bus.stall         = (ctl & C_STALL)  != 0;
        bus.branch_taken  = (ctl & C_BRANCH) != 0;
        bus.jump          = (ctl & C_JUMP)   != 0;
        bus.call          = (ctl & C_CALL)   != 0;
        bus.ret           = (ctl & C_RET)    != 0;
        bus.halt          = (ctl & C_HALT)   != 0;
        bus.resume        = (ctl & C_RESUME) != 0;
        bus.branch_target = br_tgt;
        bus.jump_target   = jmp_tgt;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input string tag);
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.jump = 1'b0;
        bus.call = 1'b0; bus.ret = 1'b0; bus.halt = 1'b0; bus.resume = 1'b0;
        bus.branch_target = 8'h00; bus.jump_target = 8'h00;
        rst_n = 1'b0;
        #2;
        check_output(tag, 8'h00, 1'b0, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        $display("[TB] starting pc_sequencer directed test");

        do_reset("reset");
        for (int i = 1; i <= 259; i++) begin
            apply_stimulus(0, 8'h00, 8'h00);
            check_output("idle_count", 8'(i), 1'b0, 1'b0, 3'd0);
        end

        do_reset("reset_t2");
        for (int i = 0; i < 16; i++) apply_stimulus(0, 8'h00, 8'h00);
        check_output("reach_10", 8'h10, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_JUMP, 8'h00, 8'h40);
        check_output("jump_40", 8'h40, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_BRANCH | C_JUMP, 8'h20, 8'h50);
        check_output("jump_over_branch", 8'h50, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_STALL, 8'h00, 8'h00);
        check_output("stall_1", 8'h50, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_STALL | C_JUMP, 8'h00, 8'h99);
        check_output("stall_2_jump_ignored", 8'h50, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_STALL, 8'h00, 8'h00);
        check_output("stall_3", 8'h50, 1'b0, 1'b0, 3'd0);
        apply_stimulus(0, 8'h00, 8'h00);
        check_output("after_stall", 8'h51, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_BRANCH, 8'h20, 8'h77);
        check_output("branch_20", 8'h20, 1'b0, 1'b0, 3'd0);

        do_reset("reset_t3");
        apply_stimulus(C_JUMP, 8'h00, 8'h05);
        check_output("jump_05", 8'h05, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_CALL, 8'h00, 8'h80);
        check_output("call_80", 8'h80, 1'b0, 1'b0, 3'd1);
        apply_stimulus(C_CALL, 8'h00, 8'hC0);
        check_output("call_C0", 8'hC0, 1'b0, 1'b0, 3'd2);
        apply_stimulus(C_RET, 8'h00, 8'h00);
        check_output("ret_81", 8'h81, 1'b0, 1'b0, 3'd1);
        apply_stimulus(C_RET, 8'h00, 8'h00);
        check_output("ret_06", 8'h06, 1'b0, 1'b0, 3'd0);

        do_reset("reset_t4");
        apply_stimulus(C_CALL, 8'h00, 8'h10);
        check_output("nest_call_1", 8'h10, 1'b0, 1'b0, 3'd1);
        apply_stimulus(C_CALL, 8'h00, 8'h20);
        check_output("nest_call_2", 8'h20, 1'b0, 1'b0, 3'd2);
        apply_stimulus(C_CALL, 8'h00, 8'h30);
        check_output("nest_call_3", 8'h30, 1'b0, 1'b0, 3'd3);
        apply_stimulus(C_CALL, 8'h00, 8'h40);
        check_output("nest_call_4", 8'h40, 1'b0, 1'b0, 3'd4);
        apply_stimulus(C_CALL, 8'h00, 8'h50);
        check_output("overflow_fault", 8'h40, 1'b0, 1'b1, 3'd4);
        apply_stimulus(C_RET, 8'h00, 8'h00);
        check_output("fault_ignores_ret", 8'h40, 1'b0, 1'b1, 3'd4);
        apply_stimulus(C_JUMP | C_RESUME, 8'h00, 8'h66);
        check_output("fault_ignores_jump", 8'h40, 1'b0, 1'b1, 3'd4);
        apply_stimulus(C_HALT, 8'h00, 8'h00);
        check_output("fault_ignores_halt", 8'h40, 1'b0, 1'b1, 3'd4);
        apply_stimulus(0, 8'h00, 8'h00);
        check_output("fault_ignores_idle", 8'h40, 1'b0, 1'b1, 3'd4);
        do_reset("reset_clears_fault");
        apply_stimulus(0, 8'h00, 8'h00);
        check_output("run_after_fault", 8'h01, 1'b0, 1'b0, 3'd0);

        do_reset("reset_t5");
        apply_stimulus(C_JUMP, 8'h00, 8'h33);
        check_output("jump_33", 8'h33, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_RET, 8'h00, 8'h00);
        check_output("underflow_fault", 8'h33, 1'b0, 1'b1, 3'd0);
        do_reset("reset_t5b");
        apply_stimulus(C_CALL, 8'h00, 8'h60);
        check_output("call_60", 8'h60, 1'b0, 1'b0, 3'd1);
        apply_stimulus(C_RET | C_CALL | C_JUMP, 8'h00, 8'h70);
        check_output("ret_wins", 8'h01, 1'b0, 1'b0, 3'd0);

        do_reset("reset_t6");
        apply_stimulus(C_JUMP, 8'h00, 8'h22);
        check_output("jump_22", 8'h22, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_STALL | C_HALT, 8'h00, 8'h00);
        check_output("stall_blocks_halt", 8'h22, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_HALT | C_CALL, 8'h00, 8'h70);
        check_output("halt_over_call", 8'h22, 1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 5; i++) begin
            apply_stimulus(0, 8'h00, 8'h00);
            check_output("halt_hold", 8'h22, 1'b1, 1'b0, 3'd0);
        end
        apply_stimulus(C_RESUME | C_STALL, 8'h00, 8'h00);
        check_output("resume_stalled", 8'h22, 1'b1, 1'b0, 3'd0);
        apply_stimulus(C_RESUME, 8'h00, 8'h00);
        check_output("resume", 8'h22, 1'b0, 1'b0, 3'd0);
        apply_stimulus(0, 8'h00, 8'h00);
        check_output("after_resume", 8'h23, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_HALT, 8'h00, 8'h00);
        check_output("halt_again", 8'h23, 1'b1, 1'b0, 3'd0);
        apply_stimulus(C_HALT | C_RESUME, 8'h00, 8'h00);
        check_output("resume_beats_halt", 8'h23, 1'b0, 1'b0, 3'd0);
        apply_stimulus(C_HALT, 8'h00, 8'h00);
        check_output("halt_third", 8'h23, 1'b1, 1'b0, 3'd0);
        do_reset("reset_mid_halt");
        apply_stimulus(0, 8'h00, 8'h00);
        check_output("run_after_halt_reset", 8'h01, 1'b0, 1'b0, 3'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
